// File: rtl/ddfs_pkg.sv
// ddfs_pkg: shared widths and enums for the ddfs sweep sequencer
package ddfs_pkg;
  localparam int DDFS_FW = 23;
  typedef enum logic [1:0] {SINGLE = 2'd0, REPEAT = 2'd1, TRIANGLE = 2'd2} sweep_mode_t;
  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, HOLD_END = 2'd2} sweep_state_t;
endpackage

// File: rtl/ddfs_step_next.sv
// ddfs_step_next: one sweep step toward stop, clamped at stop and at the word range
module ddfs_step_next #(
  parameter int FW = 23
) (
  input  logic [FW-1:0] cur,
  input  logic [FW-1:0] step,
  input  logic [FW-1:0] stop,
  input  logic          dir,
  output logic [FW-1:0] nxt,
  output logic          at_end
);
  logic [FW:0] sum;
  // the extra top bit catches overflow going up and underflow going down
  always_comb begin
    sum = dir ? {1'b0, cur} + {1'b0, step} : {1'b0, cur} - {1'b0, step};
    at_end = sum[FW] | (dir ? sum[FW-1:0] >= stop : sum[FW-1:0] <= stop);
    nxt = at_end ? stop : sum[FW-1:0];
  end
endmodule

// File: rtl/ddfs_sweep.sv
// ddfs_sweep: steps the ddfs tuning word from f_start to f_stop with a fixed dwell per value
module ddfs_sweep
  import ddfs_pkg::*;
#(
  parameter int FW = DDFS_FW,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  output logic [FW-1:0] fcontrol,
  output logic          busy,
  output logic          done,
  output logic          wrap
);
  sweep_state_t  state_q;
  logic [FW-1:0] fcontrol_q, org_q, end_q, step_q, tgt, nxt;
  logic [DW-1:0] dwell_q, cnt_q;
  logic [1:0]    mode_q;
  logic          up_q, rev_q, eq_q, busy_q, done_q, wrap_q;
  logic          eff_rev, at_end;
  // in triangle HOLD_END the step is taken in the reversed direction so endpoints are not repeated
  always_comb begin
    eff_rev = rev_q ^ (state_q == HOLD_END && mode_q == TRIANGLE);
    tgt = eff_rev ? org_q : end_q;
  end
  ddfs_step_next #(.FW(FW)) u_step (
    .cur(fcontrol_q), .step(step_q), .stop(tgt), .dir(up_q ^ eff_rev), .nxt(nxt), .at_end(at_end)
  );
  // sweep FSM with dwell counter, latched configuration and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fcontrol_q <= '0;
      org_q <= '0;
      end_q <= '0;
      step_q <= '0;
      dwell_q <= '0;
      cnt_q <= '0;
      mode_q <= '0;
      up_q <= 1'b0;
      rev_q <= 1'b0;
      eq_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start && !abort) begin
          mode_q <= mode;
          org_q <= f_start;
          end_q <= f_stop;
          step_q <= f_step;
          dwell_q <= dwell;
          fcontrol_q <= f_start;
          cnt_q <= dwell;
          up_q <= f_stop >= f_start;
          rev_q <= 1'b0;
          eq_q <= f_stop == f_start;
          busy_q <= 1'b1;
          state_q <= f_stop == f_start ? HOLD_END : SWEEP;
        end
      end else if (abort) begin
        state_q <= IDLE;
        busy_q <= 1'b0;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - DW'(1);
      end else begin
        cnt_q <= dwell_q;
        if (state_q == SWEEP) begin
          fcontrol_q <= nxt;
          state_q <= at_end ? HOLD_END : SWEEP;
          wrap_q <= at_end && rev_q;
        end else if (mode_q == REPEAT) begin
          fcontrol_q <= org_q;
          wrap_q <= 1'b1;
          state_q <= eq_q ? HOLD_END : SWEEP;
        end else if (mode_q == TRIANGLE) begin
          fcontrol_q <= nxt;
          rev_q <= eff_rev;
          wrap_q <= at_end && eff_rev;
          state_q <= at_end ? HOLD_END : SWEEP;
        end else begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
      end
    end
  end
  assign fcontrol = fcontrol_q;
  assign busy = busy_q;
  assign done = done_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_ddfs_sweep.sv
// tb_ddfs_sweep: directed checks of single, clamp, repeat, triangle, abort and reset behaviour
module tb_ddfs_sweep;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [22:0] f_start = '0;
  logic [22:0] f_stop = '0;
  logic [22:0] f_step = '0;
  logic [15:0] dwell = '0;
  logic [22:0] fcontrol;
  logic        busy, done, wrap;
  int          checks = 0;
  int          errors = 0;
  ddfs_sweep dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .fcontrol(fcontrol), .busy(busy), .done(done), .wrap(wrap)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [1:0] m, input logic [22:0] fs, input logic [22:0] fe, input logic [22:0] st, input logic [15:0] dw);
    mode = m;
    f_start = fs;
    f_stop = fe;
    f_step = st;
    dwell = dw;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic flags(input string tag, input logic b, input logic d, input logic w);
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, "_done"}, {31'd0, done}, {31'd0, d});
    chk({tag, "_wrap"}, {31'd0, wrap}, {31'd0, w});
  endtask
  task automatic hold(input string tag, input logic [22:0] v, input int n, input logic w);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_f"}, {9'd0, fcontrol}, {9'd0, v});
      flags(tag, 1'b1, 1'b0, i == 0 && w);
      tick();
    end
  endtask
  initial begin
    #2;
    chk("rst_f", {9'd0, fcontrol}, 32'd0);
    flags("rst", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    go(2'd0, 23'h100000, 23'h100300, 23'h100, 16'd3);
    hold("su0", 23'h100000, 4, 1'b0);
    hold("su1", 23'h100100, 4, 1'b0);
    hold("su2", 23'h100200, 4, 1'b0);
    hold("su3", 23'h100300, 4, 1'b0);
    chk("su_end_f", {9'd0, fcontrol}, 32'h100300);
    flags("su_end", 1'b0, 1'b1, 1'b0);
    tick();
    chk("su_after_f", {9'd0, fcontrol}, 32'h100300);
    flags("su_after", 1'b0, 1'b0, 1'b0);
    go(2'd3, 23'h7FFF00, 23'h7FFFFF, 23'h80, 16'd0);
    hold("ov0", 23'h7FFF00, 1, 1'b0);
    hold("ov1", 23'h7FFF80, 1, 1'b0);
    hold("ov2", 23'h7FFFFF, 1, 1'b0);
    flags("ov_end", 1'b0, 1'b1, 1'b0);
    go(2'd0, 23'h000100, 23'h000000, 23'h90, 16'd0);
    hold("dn0", 23'h100, 1, 1'b0);
    hold("dn1", 23'h070, 1, 1'b0);
    hold("dn2", 23'h000, 1, 1'b0);
    flags("dn_end", 1'b0, 1'b1, 1'b0);
    go(2'd0, 23'h000200, 23'h000200, 23'h5, 16'd1);
    hold("eq", 23'h200, 2, 1'b0);
    flags("eq_end", 1'b0, 1'b1, 1'b0);
    go(2'd0, 23'h000100, 23'h000200, 23'h0, 16'd0);
    hold("z", 23'h100, 10, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("z_ab_f", {9'd0, fcontrol}, 32'h100);
    flags("z_ab", 1'b0, 1'b0, 1'b0);
    go(2'd0, 23'h100000, 23'h100300, 23'h100, 16'd3);
    hold("ab0", 23'h100000, 4, 1'b0);
    chk("ab5_f", {9'd0, fcontrol}, 32'h100100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("ab_hold_f", {9'd0, fcontrol}, 32'h100100);
      flags("ab_hold", 1'b0, 1'b0, 1'b0);
      tick();
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_f", {9'd0, fcontrol}, 32'h100100);
    flags("sa", 1'b0, 1'b0, 1'b0);
    go(2'd1, 23'h000010, 23'h000030, 23'h10, 16'd1);
    hold("rp10", 23'h10, 2, 1'b0);
    hold("rp20", 23'h20, 2, 1'b0);
    hold("rp30", 23'h30, 2, 1'b0);
    hold("rp10w", 23'h10, 2, 1'b1);
    hold("rp20b", 23'h20, 2, 1'b0);
    hold("rp30b", 23'h30, 2, 1'b0);
    start = 1'b1;
    f_start = 23'h555;
    hold("rp_ign", 23'h10, 1, 1'b1);
    start = 1'b0;
    hold("rp_ign1", 23'h10, 1, 1'b0);
    hold("rp20c", 23'h20, 1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mr_f", {9'd0, fcontrol}, 32'd0);
    flags("mr", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    go(2'd2, 23'h000010, 23'h000030, 23'h10, 16'd1);
    hold("tr10", 23'h10, 2, 1'b0);
    hold("tr20", 23'h20, 2, 1'b0);
    hold("tr30", 23'h30, 2, 1'b0);
    hold("tr20d", 23'h20, 2, 1'b0);
    hold("tr10w", 23'h10, 2, 1'b1);
    hold("tr20u", 23'h20, 2, 1'b0);
    hold("tr30b", 23'h30, 2, 1'b0);
    hold("tr20e", 23'h20, 2, 1'b0);
    chk("tr10x_f", {9'd0, fcontrol}, 32'h10);
    flags("tr10x", 1'b1, 1'b0, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("tr_ab_f", {9'd0, fcontrol}, 32'h10);
    flags("tr_ab", 1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
